// File: rtl/cg_iteration_sequencer.sv
// Phase scheduler for one conjugate-gradient solve: sequences PRE, the A*p / dot / update
// phases and the convergence check, and owns the iteration count, halt/finish and watchdog.
module cg_iteration_sequencer #(
  parameter int unsigned          NO_OF_UNITS = 8,
  parameter int unsigned          ITER_WIDTH  = 11,
  parameter int unsigned          WD_WIDTH    = 16,
  parameter logic [WD_WIDTH-1:0]  WD_LIMIT    = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           total,
  input  logic [ITER_WIDTH-1:0] max_iter,
  input  logic                  converged,
  input  logic                  matvec_done,
  input  logic                  dot_pap_done,
  input  logic                  update_xr_done,
  input  logic                  dot_rr_done,
  input  logic                  update_p_done,
  output logic                  matvec_start,
  output logic                  dot_pap_start,
  output logic                  update_xr_start,
  output logic                  dot_rr_start,
  output logic                  update_p_start,
  output logic                  memories_pre_preprocess,
  output logic [31:0]           row_count,
  output logic [3:0]            phase,
  output logic                  busy,
  output logic [ITER_WIDTH-1:0] iteration_counter,
  output logic                  finish_all,
  output logic                  halt,
  output logic                  error
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    PRE       = 4'd1,
    MATVEC    = 4'd2,
    DOT_PAP   = 4'd3,
    UPDATE_XR = 4'd4,
    DOT_RR    = 4'd5,
    CHECK     = 4'd6,
    UPDATE_P  = 4'd7,
    DONE      = 4'd8,
    ERR       = 4'd9
  } state_t;

  localparam logic [31:0]         UNITS   = 32'(NO_OF_UNITS);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_LIMIT - 1'b1;

  state_t                state_q, state_d;
  logic [31:0]           rows_q, rows_d;
  logic [31:0]           pre_cnt_q, pre_cnt_d;
  logic [ITER_WIDTH-1:0] maxit_q, maxit_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [WD_WIDTH-1:0]   wd_q, wd_d;
  logic [31:0]           rows_calc;
  logic                  in_wait;

  logic mv_start_q, pap_start_q, xr_start_q, rr_start_q, up_start_q;
  logic pre_q, busy_q, finish_q, halt_q, error_q;

  assign rows_calc = total / UNITS;

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    maxit_d   = maxit_q;
    iter_d    = iter_q;
    pre_cnt_d = pre_cnt_q;
    wd_d      = wd_q;
    in_wait   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          rows_d  = rows_calc;
          maxit_d = max_iter;
          iter_d  = '0;
          state_d = (rows_calc == '0 || max_iter == '0) ? ERR : PRE;
        end
      end
      PRE: begin
        if (pre_cnt_q == rows_q - 32'd1) state_d = MATVEC;
        else                             pre_cnt_d = pre_cnt_q + 32'd1;
      end
      // A done arriving alongside its own start pulse belongs to a previous launch.
      MATVEC: begin
        in_wait = 1'b1;
        if (matvec_done && !mv_start_q) state_d = DOT_PAP;
      end
      DOT_PAP: begin
        in_wait = 1'b1;
        if (dot_pap_done && !pap_start_q) state_d = UPDATE_XR;
      end
      UPDATE_XR: begin
        in_wait = 1'b1;
        if (update_xr_done && !xr_start_q) state_d = DOT_RR;
      end
      DOT_RR: begin
        in_wait = 1'b1;
        if (dot_rr_done && !rr_start_q) state_d = CHECK;
      end
      CHECK: begin
        iter_d = (iter_q == '1) ? iter_q : iter_q + 1'b1;
        if (converged || ({1'b0, iter_q} + 1'b1 >= {1'b0, maxit_q})) state_d = DONE;
        else                                                          state_d = UPDATE_P;
      end
      UPDATE_P: begin
        in_wait = 1'b1;
        if (update_p_done && !up_start_q) state_d = MATVEC;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    if (in_wait && state_d == state_q && wd_q == WD_LAST) state_d = ERR;

    if (state_d != state_q) begin
      wd_d      = '0;
      pre_cnt_d = '0;
    end else if (in_wait) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      pre_cnt_q   <= '0;
      maxit_q     <= '0;
      iter_q      <= '0;
      wd_q        <= '0;
      mv_start_q  <= 1'b0;
      pap_start_q <= 1'b0;
      xr_start_q  <= 1'b0;
      rr_start_q  <= 1'b0;
      up_start_q  <= 1'b0;
      pre_q       <= 1'b0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      halt_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      pre_cnt_q   <= pre_cnt_d;
      maxit_q     <= maxit_d;
      iter_q      <= iter_d;
      wd_q        <= wd_d;
      mv_start_q  <= (state_d == MATVEC)    && (state_q != MATVEC);
      pap_start_q <= (state_d == DOT_PAP)   && (state_q != DOT_PAP);
      xr_start_q  <= (state_d == UPDATE_XR) && (state_q != UPDATE_XR);
      rr_start_q  <= (state_d == DOT_RR)    && (state_q != DOT_RR);
      up_start_q  <= (state_d == UPDATE_P)  && (state_q != UPDATE_P);
      pre_q       <= (state_d == PRE);
      busy_q      <= !(state_d inside {IDLE, DONE, ERR});
      finish_q    <= (state_d == DONE) && (state_q != DONE);
      halt_q      <= (state_d == DONE) || (state_d == ERR);
      error_q     <= error_q || (state_d == ERR);
    end
  end

  assign matvec_start            = mv_start_q;
  assign dot_pap_start           = pap_start_q;
  assign update_xr_start         = xr_start_q;
  assign dot_rr_start            = rr_start_q;
  assign update_p_start          = up_start_q;
  assign memories_pre_preprocess = pre_q;
  assign row_count               = rows_q;
  assign phase                   = state_q;
  assign busy                    = busy_q;
  assign iteration_counter       = iter_q;
  assign finish_all              = finish_q;
  assign halt                    = halt_q;
  assign error                   = error_q;

endmodule
